// File: rtl/input_ram_loader.sv
// Writer side of the 1-bit image input RAM: unpacks UART bytes LSB-first into
// single-bit writes, pulses start at the image boundary and waits for done.
module input_ram_loader #(
    parameter int unsigned NUM_BITS = 784,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              done,
    output logic              data,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              start,
    output logic              loading,
    output logic              overrun
);

    localparam int unsigned PixW = ADDR_W + 1;
    localparam logic [PixW-1:0] LastPix = PixW'(NUM_BITS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StStart, StWaitDone} state_e;

    state_e            state_q, state_d;
    logic [PixW-1:0]   pix_q, pix_d;
    logic [2:0]        bidx_q, bidx_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              loading_q, loading_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        bidx_d    = bidx_q;
        sr_d      = sr_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        addr_d    = addr_q;
        loading_d = loading_q;
        overrun_d = overrun_q;
        we        = 1'b0;
        start     = 1'b0;
        data      = 1'b0;
        addr      = addr_q;

        case (state_q)
            StIdle: begin
                if (rx_rdy) begin
                    sr_d      = rx_data;
                    bidx_d    = 3'd0;
                    loading_d = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                we     = 1'b1;
                addr   = pix_q[ADDR_W-1:0];
                data   = sr_q[bidx_q];
                addr_d = pix_q[ADDR_W-1:0];
                pix_d  = pix_q + PixW'(1);
                bidx_d = bidx_q + 3'd1;
                if (bidx_q == 3'd7) begin
                    if (pix_q == LastPix) begin
                        // Anything pending past the image boundary has nowhere to go.
                        if (hold_v_q || rx_rdy) overrun_d = 1'b1;
                        hold_v_d = 1'b0;
                        state_d  = StStart;
                    end else if (hold_v_q) begin
                        // Held byte goes first; a coincident new byte refills hold.
                        sr_d = hold_q;
                        if (rx_rdy) hold_d = rx_data;
                        else        hold_v_d = 1'b0;
                    end else if (rx_rdy) begin
                        sr_d = rx_data;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (rx_rdy) begin
                    if (!hold_v_q) begin
                        hold_d   = rx_data;
                        hold_v_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            StStart: begin
                start     = 1'b1;
                loading_d = 1'b0;
                pix_d     = '0;
                if (rx_rdy) overrun_d = 1'b1;
                state_d   = StWaitDone;
            end
            StWaitDone: begin
                if (rx_rdy) overrun_d = 1'b1;
                if (done)   state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pix_q     <= '0;
            bidx_q    <= 3'd0;
            sr_q      <= 8'd0;
            hold_q    <= 8'd0;
            hold_v_q  <= 1'b0;
            addr_q    <= '0;
            loading_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            bidx_q    <= bidx_d;
            sr_q      <= sr_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            addr_q    <= addr_d;
            loading_q <= loading_d;
            overrun_q <= overrun_d;
        end
    end

    assign loading = loading_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_input_ram_loader.sv
// Self-checking bench for input_ram_loader: directed scenarios plus a random
// image checked against an expected LSB-first pixel stream.
module tb_input_ram_loader;

    localparam int unsigned NUM_BITS = 784;
    localparam int unsigned ADDR_W   = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              done;
    logic              data;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              start;
    logic              loading;
    logic              overrun;

    input_ram_loader #(.NUM_BITS(NUM_BITS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .done    (done),
        .data    (data),
        .addr    (addr),
        .we      (we),
        .start   (start),
        .loading (loading),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Observed activity, sampled mid-cycle.
    int         wr_addr[$];
    int         wr_data[$];
    int         wr_cyc[$];
    int         rx_cyc[$];
    int         start_cyc[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                wr_addr.push_back(int'(addr));
                wr_data.push_back(int'(data));
                wr_cyc.push_back(cyc);
            end
            if (start)  start_cyc.push_back(cyc);
            if (rx_rdy) rx_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rx_cyc.delete();
        start_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        exp_q.push_back(b);
        wait_cyc(1);
        rx_rdy  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        clear_mon();
    endtask

    // Expected stream: write k of an image goes to addr k with bit k%8 of byte k/8.
    task automatic compare_writes(input bit contiguous);
        check("n_writes", wr_addr.size(), exp_q.size() * 8);
        for (int k = 0; k < wr_addr.size() && k < exp_q.size() * 8; k++) begin
            logic [7:0] b;
            b = exp_q[k / 8];
            check("wr_addr", wr_addr[k], k % NUM_BITS);
            check("wr_data", wr_data[k], 32'(b[k % 8]));
            if (contiguous && k > 0) check("wr_gap", wr_cyc[k] - wr_cyc[k-1], 1);
        end
        if (wr_cyc.size() > 0 && rx_cyc.size() > 0)
            check("first_lat", wr_cyc[0] - rx_cyc[0], 1);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200 && start_cyc.size() == 0; i++) wait_cyc(1);
        check("start_seen", start_cyc.size() > 0, 1);
        wait_cyc(4);
    endtask

    task automatic check_image_end();
        check("img_writes", wr_addr.size(), NUM_BITS);
        check("start_count", start_cyc.size(), 1);
        if (wr_addr.size() > 0 && start_cyc.size() > 0) begin
            check("last_addr", wr_addr[wr_addr.size()-1], NUM_BITS - 1);
            check("start_after_last", start_cyc[0] - wr_cyc[wr_cyc.size()-1], 1);
        end
        check("loading_after_start", loading, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'd0;
        done    = 1'b0;
        wait_cyc(2);
        check("rst_we", we, 0);
        check("rst_data", data, 0);
        check("rst_addr", addr, 0);
        check("rst_start", start, 0);
        check("rst_loading", loading, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        clear_mon();

        // Single byte
        send_byte(8'hA5);
        wait_cyc(10);
        compare_writes(1'b1);
        check("single_loading", loading, 1);
        check("single_we_idle", we, 0);
        check("single_overrun", overrun, 0);

        // Back-to-back: second byte three cycles after the first
        apply_reset();
        send_byte(8'h3C);
        wait_cyc(2);
        send_byte(8'hD2);
        wait_cyc(20);
        compare_writes(1'b1);
        check("b2b_overrun", overrun, 0);

        // Held byte plus a new byte exactly at bit 7: nothing dropped
        apply_reset();
        send_byte(8'h81);
        wait_cyc(2);
        send_byte(8'h7E);
        wait_cyc(4);
        send_byte(8'h96);
        wait_cyc(30);
        compare_writes(1'b1);
        check("simul_overrun", overrun, 0);

        // Overrun: three consecutive pulses, third dropped
        apply_reset();
        send_byte(8'h0F);
        send_byte(8'hF0);
        rx_rdy  = 1'b1;
        rx_data = 8'hAA;
        wait_cyc(1);
        rx_rdy  = 1'b0;
        wait_cyc(20);
        compare_writes(1'b1);
        check("ovr_overrun", overrun, 1);

        // Reset mid-WRITE, then restart from addr 0
        apply_reset();
        send_byte(8'h5A);
        wait_cyc(2);
        check("pre_rst_we", we, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_we", we, 0);
        check("midrst_start", start, 0);
        check("midrst_loading", loading, 0);
        check("midrst_addr", addr, 0);
        wait_cyc(2);
        rst_n = 1'b1;
        clear_mon();
        send_byte(8'hC3);
        wait_cyc(10);
        compare_writes(1'b1);

        // Full image of 0xFF, 20 cycles apart
        apply_reset();
        for (int i = 0; i < NUM_BITS / 8; i++) begin
            send_byte(8'hFF);
            if (i != NUM_BITS / 8 - 1) wait_cyc(19);
        end
        wait_start();
        compare_writes(1'b0);
        check_image_end();
        check("full_overrun", overrun, 0);

        // Busy drop in WAIT_DONE, then done and immediate restart
        rx_rdy  = 1'b1;
        rx_data = 8'h11;
        wait_cyc(1);
        rx_rdy  = 1'b0;
        wait_cyc(3);
        check("busy_overrun", overrun, 1);
        check("busy_no_write", wr_addr.size(), NUM_BITS);
        clear_mon();
        done = 1'b1;
        wait_cyc(1);
        done = 1'b0;
        send_byte(8'h6B);
        wait_cyc(10);
        compare_writes(1'b1);

        // Random image with random spacing of at least one byte time
        apply_reset();
        for (int i = 0; i < NUM_BITS / 8; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (i != NUM_BITS / 8 - 1) wait_cyc(int'($urandom_range(7, 13)));
        end
        wait_start();
        compare_writes(1'b0);
        check_image_end();
        for (int i = 0; i < NUM_BITS / 8 && 8 * i < wr_cyc.size() && i < rx_cyc.size(); i++)
            check("byte_lat", wr_cyc[8*i] - rx_cyc[i], 1);
        check("rand_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_ram_loader.md
# input_ram_loader

Writer side of the 1-bit-wide image input RAM (`ram_input_unit`) that `snn_core` reads. It takes received bytes from the UART receiver, unpacks each byte LSB-first into eight single-bit RAM writes at consecutive addresses, and tracks progress through the image. When a full image of NUM_BITS pixels is stored, it pulses `start` to `snn_core` and waits for `done` before accepting the next image.

## Interface
Parameters:
- NUM_BITS, 784: pixels per image; must be a multiple of 8 (NUM_BITS/8 bytes per image).
- ADDR_W, 10: RAM address width; 2^ADDR_W ≥ NUM_BITS.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_rdy  input  1  one-cycle pulse; `rx_data` valid in that cycle.
- rx_data  input  8  received byte; bit 0 is the lowest-addressed pixel.
- done  input  1  from `snn_core`; sampled high means classification finished.
- data  output  1  RAM write data.
- addr  output  ADDR_W  RAM address.
- we  output  1  RAM write enable.
- start  output  1  one-cycle pulse to `snn_core`.
- loading  output  1  high from first accepted byte of an image until `start`.
- overrun  output  1  sticky; set when a byte is dropped.

## Operation
- State machine: IDLE, WRITE, START, WAIT_DONE.
- Internal registers: pixel counter `pix` (0..NUM_BITS), bit index `bidx` (0..7), shift register `sr[7:0]`, holding register `hold[7:0]` with `hold_v`.
- IDLE: on `rx_rdy`, load `sr` ← `rx_data`, `bidx` ← 0, and set `loading`. Go to WRITE.
- WRITE: each cycle `we`=1, `addr`=`pix`, `data`=`sr[bidx]`. Then `pix`++ and `bidx`++.
  - If `bidx`=7 and `pix`=NUM_BITS-1, go to START.
  - If `bidx`=7 and `hold_v` (or `rx_rdy` this cycle), load the next byte into `sr`, clear `hold_v`, and continue WRITE with no gap.
  - If `bidx`=7 otherwise, go to IDLE.
- `rx_rdy` during WRITE:
  - If `bidx`≠7 and `hold_v`=0, latch into `hold`.
  - If `bidx`≠7 and `hold_v`=1, drop the byte and set `overrun`.
- START: `start`=1 for one cycle, `loading` ← 0, `pix` ← 0. Go to WAIT_DONE.
- WAIT_DONE: when `done`=1, go to IDLE. `rx_rdy` here is dropped and sets `overrun`. A held byte cannot exist in this state because the image was full.
- Data bits beyond NUM_BITS are never written. A byte that would overflow the image cannot occur, since START is entered exactly at the image boundary.
- `overrun` clears only on reset.
- `we` is 0 in every state except WRITE. In all non-WRITE states, `addr` holds its last value and `data`=0.

## Timing
- Reset values (asynchronous): state IDLE; `we`=0, `data`=0, `addr`=0, `start`=0, `loading`=0, `overrun`=0; `pix`=0, `hold_v`=0.
- Latency, `rx_rdy` (cycle N) to first write: first write at cycle N+1.
- Byte writes: the byte's 8 writes occupy cycles N+1..N+8.
- Last pixel: written in cycle L. `start` is high in cycle L+1 and is exactly one cycle wide.
- `done` high in cycle D (D ≥ L+2) gives IDLE in D+1. An `rx_rdy` in D+1 is accepted as byte 0 of the next image at `addr` 0.
- `done` during IDLE, WRITE or START is ignored.
- Back-to-back bytes: throughput is one byte per 8 cycles with no idle cycle between bytes.
- Simultaneous events: `rx_rdy` in the same cycle as `bidx`=7 of a byte that is not the last is taken directly into `sr` and counts as the continuation byte. If `hold_v` is also set in that cycle:
  - `hold` is consumed first;
  - the new byte goes into `hold`;
  - nothing is dropped.
- Reset mid-load: all outputs drop immediately (asynchronously). After reset, the next byte writes from `addr` 0.
- Full image: exactly NUM_BITS cycles with `we`=1 per image.

## Test plan
- Reset check: assert `rst_n`=0 mid-WRITE. `we`, `start`, `loading` and `addr` must go to 0 before the next clock edge; the next byte must write from `addr` 0.
- Single byte: `rx_data`=0xA5. Cycles N+1..N+8 must write addr 0..7 with data 1,0,1,0,0,1,0,1, then return to IDLE with `loading`=1.
- Full image: 98 bytes of 0xFF spaced 20 cycles apart. The bench must count exactly 784 `we` cycles, a last write at addr 783, and a `start` pulse one cycle wide immediately after. The same stimulus must run through `snn_core` to `done`.
- Back-to-back: second `rx_rdy` 3 cycles after the first. Addr 0..15 must be written in 16 consecutive cycles with no gap, and `overrun`=0.
- Overrun: three `rx_rdy` pulses on consecutive cycles. The third byte must be dropped with `overrun`=1, and only 16 writes may occur.
- Busy drop and restart: `rx_rdy` in WAIT_DONE must set `overrun` with no write. After `done`, the next byte must write starting at addr 0.
